// File: rtl/fifo_multicanal_pkg.sv
// rtl/fifo_multicanal_pkg.sv - shared defaults and helpers for the multi-channel FIFO
//
// Purpose : default geometry of the multi-channel FIFO and a constant-evaluable
//           ceil(log2) used to derive pointer and channel-index widths.
// Contents: DEF_TAMANO_DATOS, DEF_PROFUNDIDAD, DEF_N_CANALES, clog2()
package fifo_multicanal_pkg;

    localparam int DEF_TAMANO_DATOS = 10;
    localparam int DEF_PROFUNDIDAD  = 8;
    localparam int DEF_N_CANALES    = 4;

    // Smallest r with 2**r >= valor; loop bound kept below 31 so the shift never
    // reaches the sign bit of a 32-bit int.
    function automatic int clog2(input int valor);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < valor) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_canal.sv
// rtl/fifo_canal.sv - one FIFO channel: storage, pointers, occupancy and flags
//
// Purpose : single independent FIFO channel used by fifo_multicanal.
// Ports   : clk, reset            clock, asynchronous active-low reset
//           i_we, i_re            write / read request already decoded for this channel
//           i_data                write data
//           i_umbral_bajo/alto    almost_empty / almost_full thresholds
//           o_rd_data             word at the read pointer (combinational)
//           o_cnt                 occupancy (0..PROFUNDIDAD)
//           o_full, o_empty, o_almost_full, o_almost_empty   status flags
//           o_we_ok, o_re_ok      request accepted this cycle
module fifo_canal #(
    parameter int TAMANO_DATOS = 10,
    parameter int PROFUNDIDAD  = 8,
    parameter int ANCHO_PTR    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [TAMANO_DATOS-1:0] i_data,
    input  logic [ANCHO_PTR:0]      i_umbral_bajo,
    input  logic [ANCHO_PTR:0]      i_umbral_alto,
    output logic [TAMANO_DATOS-1:0] o_rd_data,
    output logic [ANCHO_PTR:0]      o_cnt,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic                    o_we_ok,
    output logic                    o_re_ok
);

    localparam logic [ANCHO_PTR:0] CNT_LLENO = (ANCHO_PTR + 1)'(PROFUNDIDAD);

    logic [TAMANO_DATOS-1:0] r_mem [PROFUNDIDAD];
    logic [ANCHO_PTR-1:0]    r_wr_ptr;
    logic [ANCHO_PTR-1:0]    r_rd_ptr;
    logic [ANCHO_PTR:0]      r_cnt;

    // Flags come from the registered count only, so a same-cycle read never
    // makes room for a write to a full channel and a same-cycle write never
    // feeds a read of an empty one.
    assign o_full         = (r_cnt == CNT_LLENO);
    assign o_empty        = (r_cnt == '0);
    assign o_almost_full  = (r_cnt >= i_umbral_alto);
    assign o_almost_empty = (r_cnt <= i_umbral_bajo);
    assign o_we_ok        = i_we && !o_full;
    assign o_re_ok        = i_re && !o_empty;
    assign o_cnt          = r_cnt;
    assign o_rd_data      = r_mem[r_rd_ptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (o_we_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally since PROFUNDIDAD is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (o_we_ok) begin
                r_wr_ptr <= r_wr_ptr + ANCHO_PTR'(1);
            end
            if (o_re_ok) begin
                r_rd_ptr <= r_rd_ptr + ANCHO_PTR'(1);
            end
            case ({o_we_ok, o_re_ok})
                2'b10:   r_cnt <= r_cnt + (ANCHO_PTR + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (ANCHO_PTR + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/fifo_multicanal.sv
// rtl/fifo_multicanal.sv - N independent FIFO channels behind shared write/read ports
//
// Purpose : per-destination buffering between packet demux and arbiter.
// Ports   : clk, reset                   clock, asynchronous active-low reset
//           write_enable, wr_canal, data_in   shared write port
//           read_enable, rd_canal        shared read port
//           umbral_bajo, umbral_alto     almost_empty / almost_full thresholds
//           error_clr                    clears every sticky error bit
//           data_out, valid_out          registered read data, one cycle latency
//           full, empty, almost_full, almost_empty, error   per-channel vectors
//           ocupacion                    count of channel rd_canal (combinational)
module fifo_multicanal
    import fifo_multicanal_pkg::*;
#(
    parameter int TAMANO_DATOS = DEF_TAMANO_DATOS,
    parameter int PROFUNDIDAD  = DEF_PROFUNDIDAD,
    parameter int N_CANALES    = DEF_N_CANALES,
    parameter int ANCHO_PTR    = clog2(PROFUNDIDAD),
    parameter int ANCHO_CANAL  = clog2(N_CANALES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_enable,
    input  logic [ANCHO_CANAL-1:0]  wr_canal,
    input  logic [TAMANO_DATOS-1:0] data_in,
    input  logic                    read_enable,
    input  logic [ANCHO_CANAL-1:0]  rd_canal,
    input  logic [ANCHO_PTR:0]      umbral_bajo,
    input  logic [ANCHO_PTR:0]      umbral_alto,
    input  logic                    error_clr,
    output logic [TAMANO_DATOS-1:0] data_out,
    output logic                    valid_out,
    output logic [N_CANALES-1:0]    full,
    output logic [N_CANALES-1:0]    empty,
    output logic [N_CANALES-1:0]    almost_full,
    output logic [N_CANALES-1:0]    almost_empty,
    output logic [N_CANALES-1:0]    error,
    output logic [ANCHO_PTR:0]      ocupacion
);

    logic [N_CANALES-1:0]    w_we;
    logic [N_CANALES-1:0]    w_re;
    logic [N_CANALES-1:0]    w_we_ok;
    logic [N_CANALES-1:0]    w_re_ok;
    logic [N_CANALES-1:0]    w_err_pulse;
    logic [TAMANO_DATOS-1:0] w_rd_data [N_CANALES];
    logic [ANCHO_PTR:0]      w_cnt     [N_CANALES];
    logic                    w_rd_ok;

    logic [TAMANO_DATOS-1:0] r_data_out;
    logic                    r_valid_out;
    logic [N_CANALES-1:0]    r_error;

    for (genvar g = 0; g < N_CANALES; g++) begin : g_canal
        assign w_we[g] = write_enable && (wr_canal == ANCHO_CANAL'(g));
        assign w_re[g] = read_enable  && (rd_canal == ANCHO_CANAL'(g));

        fifo_canal #(
            .TAMANO_DATOS (TAMANO_DATOS),
            .PROFUNDIDAD  (PROFUNDIDAD),
            .ANCHO_PTR    (ANCHO_PTR)
        ) u_canal (
            .clk            (clk),
            .reset          (reset),
            .i_we           (w_we[g]),
            .i_re           (w_re[g]),
            .i_data         (data_in),
            .i_umbral_bajo  (umbral_bajo),
            .i_umbral_alto  (umbral_alto),
            .o_rd_data      (w_rd_data[g]),
            .o_cnt          (w_cnt[g]),
            .o_full         (full[g]),
            .o_empty        (empty[g]),
            .o_almost_full  (almost_full[g]),
            .o_almost_empty (almost_empty[g]),
            .o_we_ok        (w_we_ok[g]),
            .o_re_ok        (w_re_ok[g])
        );
    end

    // A request that reached its channel but was not accepted is an
    // overflow (write) or underflow (read).
    assign w_err_pulse = (w_we & ~w_we_ok) | (w_re & ~w_re_ok);
    assign w_rd_ok     = |w_re_ok;
    assign ocupacion   = w_cnt[rd_canal];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_rd_ok;
            if (w_rd_ok) begin
                r_data_out <= w_rd_data[rd_canal];
            end
        end
    end

    // Clear first, then OR in fresh errors so a same-edge error survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error <= '0;
        end else begin
            r_error <= (r_error & ~{N_CANALES{error_clr}}) | w_err_pulse;
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign error     = r_error;

endmodule

// File: tb/tb_fifo_multicanal.sv
// tb/tb_fifo_multicanal.sv - directed self-checking bench for fifo_multicanal
module tb_fifo_multicanal;

    logic       clk;
    logic       reset;
    logic       write_enable;
    logic [1:0] wr_canal;
    logic [9:0] data_in;
    logic       read_enable;
    logic [1:0] rd_canal;
    logic [3:0] umbral_bajo;
    logic [3:0] umbral_alto;
    logic       error_clr;
    logic [9:0] data_out;
    logic       valid_out;
    logic [3:0] full;
    logic [3:0] empty;
    logic [3:0] almost_full;
    logic [3:0] almost_empty;
    logic [3:0] error;
    logic [3:0] ocupacion;

    int n_checks;
    int n_fail;

    fifo_multicanal dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .wr_canal     (wr_canal),
        .data_in      (data_in),
        .read_enable  (read_enable),
        .rd_canal     (rd_canal),
        .umbral_bajo  (umbral_bajo),
        .umbral_alto  (umbral_alto),
        .error_clr    (error_clr),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
        .ocupacion    (ocupacion)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task tick();
        @(posedge clk);
        #1;
    endtask

    task idle();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        error_clr    = 1'b0;
    endtask

    task test_reset();
        reset        = 1'b0;
        idle();
        wr_canal     = 2'd0;
        rd_canal     = 2'd0;
        data_in      = '0;
        umbral_bajo  = 4'd2;
        umbral_alto  = 4'd6;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        n_checks++; if (empty !== 4'b1111) begin n_fail++; $display("FAIL reset_empty: got %b expected %b", empty, 4'b1111); end
        n_checks++; if (almost_empty !== 4'b1111) begin n_fail++; $display("FAIL reset_almost_empty: got %b expected %b", almost_empty, 4'b1111); end
        n_checks++; if (full !== 4'b0000) begin n_fail++; $display("FAIL reset_full: got %b expected %b", full, 4'b0000); end
        n_checks++; if (almost_full !== 4'b0000) begin n_fail++; $display("FAIL reset_almost_full: got %b expected %b", almost_full, 4'b0000); end
        n_checks++; if (error !== 4'b0000) begin n_fail++; $display("FAIL reset_error: got %b expected %b", error, 4'b0000); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected %b", valid_out, 1'b0); end
        n_checks++; if (data_out !== 10'h000) begin n_fail++; $display("FAIL reset_data_out: got %h expected %h", data_out, 10'h000); end
        n_checks++; if (ocupacion !== 4'd0) begin n_fail++; $display("FAIL reset_ocupacion: got %0d expected %0d", ocupacion, 0); end
    endtask

    task test_fill_overflow();
        rd_canal = 2'd2;
        for (int k = 1; k <= 8; k++) begin
            write_enable = 1'b1;
            wr_canal     = 2'd2;
            data_in      = 10'(k);
            tick();
            n_checks++; if (ocupacion !== 4'(k)) begin n_fail++; $display("FAIL fill_cnt[%0d]: got %0d expected %0d", k, ocupacion, k); end
            n_checks++; if (almost_full[2] !== (k >= 6)) begin n_fail++; $display("FAIL fill_almost_full[%0d]: got %b expected %b", k, almost_full[2], (k >= 6)); end
            n_checks++; if (full !== ((k == 8) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", k, full, ((k == 8) ? 4'b0100 : 4'b0000)); end
        end
        n_checks++; if (error !== 4'b0000) begin n_fail++; $display("FAIL fill_no_error: got %b expected %b", error, 4'b0000); end
        data_in = 10'h3FF;
        tick();
        idle();
        n_checks++; if (error !== 4'b0100) begin n_fail++; $display("FAIL overflow_error: got %b expected %b", error, 4'b0100); end
        n_checks++; if (ocupacion !== 4'd8) begin n_fail++; $display("FAIL overflow_cnt: got %0d expected %0d", ocupacion, 8); end
        n_checks++; if (full[2] !== 1'b1) begin n_fail++; $display("FAIL overflow_full: got %b expected %b", full[2], 1'b1); end
    endtask

    task test_drain();
        read_enable = 1'b1;
        rd_canal    = 2'd2;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b expected %b", k, valid_out, 1'b1); end
            n_checks++; if (data_out !== 10'(k)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", k, data_out, 10'(k)); end
            n_checks++; if (ocupacion !== 4'(8 - k)) begin n_fail++; $display("FAIL drain_cnt[%0d]: got %0d expected %0d", k, ocupacion, 8 - k); end
            n_checks++; if (almost_empty[2] !== ((8 - k) <= 2)) begin n_fail++; $display("FAIL drain_almost_empty[%0d]: got %b expected %b", k, almost_empty[2], ((8 - k) <= 2)); end
            n_checks++; if (empty[2] !== (k == 8)) begin n_fail++; $display("FAIL drain_empty[%0d]: got %b expected %b", k, empty[2], (k == 8)); end
        end
        idle();
        tick();
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL drain_idle_valid: got %b expected %b", valid_out, 1'b0); end
        n_checks++; if (data_out !== 10'h008) begin n_fail++; $display("FAIL drain_hold_data: got %h expected %h", data_out, 10'h008); end
    endtask

    task test_cross_channel();
        write_enable = 1'b1;
        wr_canal     = 2'd1;
        data_in      = 10'h0AA;
        read_enable  = 1'b1;
        rd_canal     = 2'd3;
        tick();
        idle();
        n_checks++; if (error !== 4'b1100) begin n_fail++; $display("FAIL cross_error: got %b expected %b", error, 4'b1100); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL cross_valid: got %b expected %b", valid_out, 1'b0); end
        n_checks++; if (empty !== 4'b1101) begin n_fail++; $display("FAIL cross_empty: got %b expected %b", empty, 4'b1101); end
        n_checks++; if (almost_empty !== 4'b1111) begin n_fail++; $display("FAIL cross_almost_empty: got %b expected %b", almost_empty, 4'b1111); end
        n_checks++; if (full !== 4'b0000) begin n_fail++; $display("FAIL cross_full: got %b expected %b", full, 4'b0000); end
        rd_canal = 2'd1;
        #1;
        n_checks++; if (ocupacion !== 4'd1) begin n_fail++; $display("FAIL cross_ch1_cnt: got %0d expected %0d", ocupacion, 1); end
        error_clr = 1'b1;
        tick();
        idle();
        n_checks++; if (error !== 4'b0000) begin n_fail++; $display("FAIL error_clr: got %b expected %b", error, 4'b0000); end
        // Clear and a fresh underflow on ch3 at the same edge: the new error stays.
        error_clr   = 1'b1;
        read_enable = 1'b1;
        rd_canal    = 2'd3;
        tick();
        idle();
        n_checks++; if (error !== 4'b1000) begin n_fail++; $display("FAIL clr_vs_new_error: got %b expected %b", error, 4'b1000); end
        error_clr = 1'b1;
        tick();
        idle();
        n_checks++; if (error !== 4'b0000) begin n_fail++; $display("FAIL error_clr_again: got %b expected %b", error, 4'b0000); end
        read_enable = 1'b1;
        rd_canal    = 2'd1;
        tick();
        idle();
        n_checks++; if (data_out !== 10'h0AA || valid_out !== 1'b1) begin n_fail++; $display("FAIL cross_ch1_read: got %h/%b expected %h/%b", data_out, valid_out, 10'h0AA, 1'b1); end
        n_checks++; if (empty !== 4'b1111) begin n_fail++; $display("FAIL cross_all_empty: got %b expected %b", empty, 4'b1111); end
    endtask

    task test_back_to_back();
        rd_canal = 2'd0;
        for (int j = 0; j < 4; j++) begin
            write_enable = 1'b1;
            wr_canal     = 2'd0;
            data_in      = 10'(12'h100 + j);
            tick();
        end
        idle();
        n_checks++; if (ocupacion !== 4'd4) begin n_fail++; $display("FAIL b2b_prefill_cnt: got %0d expected %0d", ocupacion, 4); end
        for (int k = 0; k < 20; k++) begin
            write_enable = 1'b1;
            wr_canal     = 2'd0;
            data_in      = 10'(12'h104 + k);
            read_enable  = 1'b1;
            rd_canal     = 2'd0;
            tick();
            n_checks++; if (valid_out !== 1'b1 || data_out !== 10'(12'h100 + k)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h/%b expected %h/%b", k, data_out, valid_out, 10'(12'h100 + k), 1'b1); end
            n_checks++; if (ocupacion !== 4'd4) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d expected %0d", k, ocupacion, 4); end
        end
        idle();
        n_checks++; if (error !== 4'b0000) begin n_fail++; $display("FAIL b2b_error: got %b expected %b", error, 4'b0000); end
    endtask

    task test_reset_mid();
        // ch0 holds 0x114..0x117; one more write brings it to 5.
        write_enable = 1'b1;
        wr_canal     = 2'd0;
        data_in      = 10'h118;
        tick();
        idle();
        n_checks++; if (ocupacion !== 4'd5) begin n_fail++; $display("FAIL mid_cnt5: got %0d expected %0d", ocupacion, 5); end
        read_enable = 1'b1;
        rd_canal    = 2'd0;
        tick();
        n_checks++; if (data_out !== 10'h114 || valid_out !== 1'b1) begin n_fail++; $display("FAIL mid_read: got %h/%b expected %h/%b", data_out, valid_out, 10'h114, 1'b1); end
        reset = 1'b0;
        #1;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected %b", valid_out, 1'b0); end
        n_checks++; if (data_out !== 10'h000) begin n_fail++; $display("FAIL mid_reset_data: got %h expected %h", data_out, 10'h000); end
        n_checks++; if (empty !== 4'b1111) begin n_fail++; $display("FAIL mid_reset_empty: got %b expected %b", empty, 4'b1111); end
        n_checks++; if (ocupacion !== 4'd0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d expected %0d", ocupacion, 0); end
        idle();
        #2;
        reset = 1'b1;
        tick();
        write_enable = 1'b1;
        wr_canal     = 2'd0;
        data_in      = 10'h155;
        tick();
        idle();
        read_enable = 1'b1;
        rd_canal    = 2'd0;
        tick();
        idle();
        n_checks++; if (data_out !== 10'h155 || valid_out !== 1'b1) begin n_fail++; $display("FAIL post_reset_read: got %h/%b expected %h/%b", data_out, valid_out, 10'h155, 1'b1); end
        n_checks++; if (empty !== 4'b1111) begin n_fail++; $display("FAIL post_reset_empty: got %b expected %b", empty, 4'b1111); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill_overflow();
        test_drain();
        test_cross_channel();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
